// File: rtl/banked_ram_pkg.sv
// Shared helpers for the banked scratchpad RAM crossbar: address-split
// derivations, port-id sizing and the conflict-counter saturation value.
package banked_ram_pkg;

   // Width of the within-bank word index once the bank tag is removed.
   function automatic int local_addr_w(input int addr_w, input int tag_w);
      return addr_w - tag_w;
   endfunction

   // Number of banks addressed by a tag of the given width.
   function automatic int num_banks(input int tag_w);
      return 1 << tag_w;
   endfunction

   // Bits needed to hold a port index; a single-port build still needs one bit.
   function automatic int port_id_w(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // All-ones value the conflict counter stops at, for a counter of cnt_w bits.
   function automatic logic [63:0] cnt_sat(input int cnt_w);
      return (cnt_w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cnt_w) - 64'd1);
   endfunction

endpackage

// File: rtl/banked_ram_arb.sv
// Per-bank arbiter: picks exactly one requesting port, one-hot grant.
// Default build is fixed priority (lowest port index wins, no state).
// With BANKED_RAM_RR_ARB_EN defined it becomes round-robin with a pointer
// that restarts the search one past the last granted port.
module banked_ram_arb
   import banked_ram_pkg::*;
#(
   parameter int NUM_PORTS = 4
) (
`ifdef BANKED_RAM_RR_ARB_EN
   input  logic                 clk,
   input  logic                 reset,
`endif
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt
);

`ifdef BANKED_RAM_RR_ARB_EN
   localparam int PID_W = port_id_w(NUM_PORTS);

   logic [PID_W-1:0] ptr_q;
   logic [PID_W-1:0] ptr_d;
   logic [PID_W-1:0] idx;
   logic             found;

   // Search from the pointer, wrapping; first requester found gets the grant.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = PID_W'((int'(ptr_q) + i) % NUM_PORTS);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
            ptr_d    = PID_W'((int'(idx) + 1) % NUM_PORTS);
         end
      end
   end

   // Pointer only moves in cycles that grant something.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic found;

   // Fixed priority: the lowest-indexed requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/banked_ram_xbar.sv
// Multi-port banked scratchpad RAM. NUM_PORTS requesters share 2^TAG_W
// single-ported banks; each bank grants one port per cycle and losing ports
// stall with req_ready low. Reads return one cycle after the grant.
// Optional feature: define BANKED_RAM_RR_ARB_EN for round-robin arbitration.
//
// Handshake: a transfer happens on a rising edge where req_valid[p] and
// req_ready[p] are both high. req_ready is combinational from req_valid and
// req_addr; a port left waiting must hold valid/we/addr/wdata stable until
// it sees req_ready. rsp_valid[p] pulses for one cycle per granted read and
// has no backpressure.
module banked_ram_xbar
   import banked_ram_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int TAG_W      = 2,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 13,
   parameter int CNT_W      = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             req_valid,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             rsp_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_data,
   output logic [CNT_W-1:0]                 conflict_count
);

   localparam int NUM_BANKS = num_banks(TAG_W);
   localparam int LOCAL_W   = local_addr_w(ADDR_WIDTH, TAG_W);
   localparam int DEPTH     = 1 << LOCAL_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

   logic [TAG_W-1:0]      port_tag   [NUM_PORTS];
   logic [LOCAL_W-1:0]    port_local [NUM_PORTS];
   logic [NUM_PORTS-1:0]  bank_gnt   [NUM_BANKS];
   logic [DATA_WIDTH-1:0] bank_rd    [NUM_BANKS];
   logic [TAG_W-1:0]      bank_id_q  [NUM_PORTS];
   logic [NUM_PORTS-1:0]  rsp_valid_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  any_stall;

   // Split each port address into bank tag (top bits) and local index.
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_tag[p]   = req_addr[p*ADDR_WIDTH + LOCAL_W +: TAG_W];
         port_local[p] = req_addr[p*ADDR_WIDTH +: LOCAL_W];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [NUM_PORTS-1:0]  breq;
      logic [NUM_PORTS-1:0]  bgnt;
      logic                  sel_any;
      logic                  sel_we;
      logic [LOCAL_W-1:0]    sel_addr;
      logic [DATA_WIDTH-1:0] sel_wdata;
      logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
      logic [DATA_WIDTH-1:0] rd_q;

      // Candidates for this bank: valid ports whose tag selects it.
      always_comb begin
         breq = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            breq[p] = req_valid[p] && (port_tag[p] == TAG_W'(b));
         end
      end

      banked_ram_arb #(
         .NUM_PORTS (NUM_PORTS)
      ) u_arb (
`ifdef BANKED_RAM_RR_ARB_EN
         .clk   (clk),
         .reset (reset),
`endif
         .req   (breq),
         .gnt   (bgnt)
      );

      // Route the granted port's command onto the bank (grant is one-hot).
      always_comb begin
         sel_any   = |bgnt;
         sel_we    = 1'b0;
         sel_addr  = '0;
         sel_wdata = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (bgnt[p]) begin
               sel_we    = req_we[p];
               sel_addr  = port_local[p];
               sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      // Storage array; contents survive reset.
      always_ff @(posedge clk) begin
         if (sel_any && sel_we) begin
            mem[sel_addr] <= sel_wdata;
         end
      end

      // Bank output register loads only on a granted read.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_q <= '0;
         end else if (sel_any && !sel_we) begin
            rd_q <= mem[sel_addr];
         end
      end

      assign bank_gnt[b] = bgnt;
      assign bank_rd[b]  = rd_q;
   end

   // A port's ready is its grant from whichever bank it addressed.
   always_comb begin
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         req_ready = req_ready | bank_gnt[b];
      end
   end

   // Remember which bank served each port's read so the response can be steered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            bank_id_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid_q[p] <= req_valid[p] && req_ready[p] && !req_we[p];
            if (req_valid[p] && req_ready[p]) begin
               bank_id_q[p] <= port_tag[p];
            end
         end
      end
   end

   // Response data: read register of the bank each port used last edge.
   always_comb begin
      rsp_data = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = bank_rd[bank_id_q[p]];
      end
   end

   assign any_stall = |(req_valid & ~req_ready);

   // Saturating count of cycles in which at least one valid port stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (any_stall && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign rsp_valid      = rsp_valid_q;
   assign conflict_count = cnt_q;

endmodule

// File: tb/tb_banked_ram_xbar.sv
// Directed bench for banked_ram_xbar (4 ports, 4 banks, 16-bit words).
// Expectations for the conflict test follow BANKED_RAM_RR_ARB_EN when set.
module tb_banked_ram_xbar;

   localparam int NP = 4;
   localparam int AW = 13;
   localparam int DW = 16;
   localparam int CW = 16;

   logic             clk;
   logic             reset;
   logic [NP-1:0]    req_valid;
   logic [NP-1:0]    req_ready;
   logic [NP-1:0]    req_we;
   logic [NP*AW-1:0] req_addr;
   logic [NP*DW-1:0] req_wdata;
   logic [NP-1:0]    rsp_valid;
   logic [NP*DW-1:0] rsp_data;
   logic [CW-1:0]    conflict_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];

   banked_ram_xbar #(
      .NUM_PORTS  (NP),
      .TAG_W      (2),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .conflict_count (conflict_count)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drivers
   task automatic drive_port(input int p, input logic v, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      req_valid[p]            = v;
      req_we[p]               = we;
      req_addr[p*AW +: AW]    = addr;
      req_wdata[p*DW +: DW]   = wd;
   endtask

   task automatic idle_all();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      idle_all();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   logic [NP-1:0] exp_rdy;

   initial begin
      idle_all();
      reset = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check_val("rst_conflict", 64'(conflict_count), 64'h0);
      check_val("rst_req_ready", 64'(req_ready), 64'h0);
      check_val("rst_rsp_data", rsp_data, 64'h0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_val($sformatf("post_rst_rsp_valid_%0d", i), 64'(rsp_valid), 64'h0);
      end

      // ---- write then read-after-write on another port ----
      @(negedge clk);
      drive_port(0, 1'b1, 1'b1, 13'h0005, 16'hBEEF);
      #1 check_val("wr_ready", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      check_val("wr_no_rsp", 64'(rsp_valid), 64'h0);
      @(negedge clk);
      idle_all();
      drive_port(1, 1'b1, 1'b0, 13'h0005, 16'h0);
      #1 check_val("rd_ready", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      check_val("rd_rsp_valid", 64'(rsp_valid), 64'h2);
      check_val("rd_rsp_data1", 64'(rsp_data[1*DW +: DW]), 64'hBEEF);
      @(negedge clk);
      idle_all();
      @(posedge clk); #1;
      check_val("rd_rsp_pulse", 64'(rsp_valid), 64'h0);

      // ---- all four banks in parallel: port p writes bank 3-p ----
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         drive_port(p, 1'b1, 1'b1, 13'((3 - p) << 11), 16'hC0D0 + 16'(3 - p));
      end
      #1 check_val("par_wr_ready", 64'(req_ready), 64'hF);
      @(negedge clk);
      idle_all();
      for (int p = 0; p < NP; p++) begin
         drive_port(p, 1'b1, 1'b0, 13'(p << 11), 16'h0);
         exp_q.push_back(16'hC0D0 + 16'(p));
      end
      #1 check_val("par_rd_ready", 64'(req_ready), 64'hF);
      @(posedge clk); #1;
      check_val("par_rsp_valid", 64'(rsp_valid), 64'hF);
      for (int p = 0; p < NP; p++) begin
         check_val($sformatf("par_rsp_data%0d", p), 64'(rsp_data[p*DW +: DW]), 64'(exp_q.pop_front()));
      end
      check_val("par_conflict", 64'(conflict_count), 64'h0);

      // ---- same-bank conflict: ports 0 and 2 hammer bank 1 ----
      pulse_reset();
      @(negedge clk);
      check_val("cf_cnt_cleared", 64'(conflict_count), 64'h0);
      drive_port(0, 1'b1, 1'b0, 13'h0800, 16'h0);
      drive_port(2, 1'b1, 1'b0, 13'h0801, 16'h0);
      for (int i = 0; i < 4; i++) begin
`ifdef BANKED_RAM_RR_ARB_EN
         exp_rdy = (i % 2 == 0) ? 4'b0001 : 4'b0100;
`else
         exp_rdy = 4'b0001;
`endif
         #1 check_val($sformatf("cf_ready_%0d", i), 64'(req_ready), 64'(exp_rdy));
         @(posedge clk);
         @(negedge clk);
      end
      check_val("cf_cnt4", 64'(conflict_count), 64'd4);

      // ---- sustain the conflict to saturation (70000 cycles total) ----
      repeat (65530) @(posedge clk);
      #1 check_val("sat_below", 64'(conflict_count), 64'hFFFE);
      repeat (70000 - 4 - 65530) @(posedge clk);
      #1 check_val("sat_top", 64'(conflict_count), 64'hFFFF);
      @(negedge clk);
      idle_all();
      @(posedge clk); #1;
      check_val("sat_hold", 64'(conflict_count), 64'hFFFF);

      // ---- reset while a read response is in flight ----
      @(negedge clk);
      drive_port(3, 1'b1, 1'b0, 13'h0005, 16'h0);
      #1 check_val("mid_ready3", 64'(req_ready), 64'h8);
      @(posedge clk); #1;
      check_val("mid_rsp3", 64'(rsp_valid), 64'h8);
      #1 reset = 1'b0;
      #1;
      check_val("mid_async_drop", 64'(rsp_valid), 64'h0);
      check_val("mid_cnt_clear", 64'(conflict_count), 64'h0);
      @(negedge clk);
      idle_all();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val($sformatf("mid_no_replay_%0d", i), 64'(rsp_valid), 64'h0);
      end
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 13'h0005, 16'h0);
      @(posedge clk); #1;
      check_val("keep_rsp_valid", 64'(rsp_valid), 64'h1);
      check_val("keep_rsp_data0", 64'(rsp_data[0 +: DW]), 64'hBEEF);
      @(negedge clk);
      idle_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
